// File: rtl/cart_arb_pkg.sv
// cart_arb_pkg: shared types and constants for the cartridge memory arbiter.
// Optional build macro CART_ARB_CHR_PRIO_EN is consumed by cart_mem_arbiter.
package cart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRG  = 2'd1,
    CHR  = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_PRG = 1'b0,
    SIDE_CHR = 1'b1
  } side_t;

  localparam int         TIMEOUT_DEF = 255;
  localparam logic [7:0] RDATA_ABORT = 8'hFF;

endpackage

// File: rtl/cart_arb_port.sv
// cart_arb_port: one requester side -- pending flag, request latch,
// overrun detect, read-data register and done pulse.
module cart_arb_port
  import cart_arb_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_cmp,
  input  logic [DATA_W-1:0] i_cmp_data,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done,
  output logic              o_ovr
);

  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_done;

  // a request is dropped while this side is pending or in service
  assign o_ovr   = i_req & r_pend;
  assign o_pend  = r_pend;
  assign o_addr  = r_addr;
  assign o_we    = r_we;
  assign o_wdata = r_wdata;
  assign o_rdata = r_rdata;
  assign o_done  = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= i_cmp;
      if (i_cmp) begin
        r_pend <= 1'b0;
        if (!r_we) r_rdata <= i_cmp_data;
      end
      if (i_req && !r_pend) begin
        r_pend  <= 1'b1;
        r_addr  <= i_addr;
        r_we    <= i_we;
        r_wdata <= i_wdata;
      end
    end
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares the cartridge memory port between PRG and CHR.
// Define CART_ARB_CHR_PRIO_EN for fixed CHR priority; default is round-robin.
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prg_req,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic              prg_we,
  input  logic [DATA_W-1:0] prg_wdata,
  output logic [DATA_W-1:0] prg_rdata,
  output logic              prg_done,
  input  logic              chr_req,
  input  logic [ADDR_W-1:0] chr_addr,
  input  logic              chr_we,
  input  logic [DATA_W-1:0] chr_wdata,
  output logic [DATA_W-1:0] chr_rdata,
  output logic              chr_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  state_t            r_state;
  side_t             r_last;
  logic [7:0]        r_wdog;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_err;

  logic              w_prg_pend, w_chr_pend;
  logic [ADDR_W-1:0] w_prg_addr, w_chr_addr;
  logic              w_prg_we, w_chr_we;
  logic [DATA_W-1:0] w_prg_wdata, w_chr_wdata;
  logic              w_prg_ovr, w_chr_ovr;
  logic              w_busy, w_tmo, w_fin;
  logic              w_prg_cmp, w_chr_cmp;
  logic              w_pick_prg, w_pick_chr;
  logic [DATA_W-1:0] w_cmp_data;

  assign w_busy     = (r_state == PRG) | (r_state == CHR);
  assign w_tmo      = w_busy & ~mem_ack
                    & (r_wdog == 8'(TIMEOUT - 1));
  assign w_fin      = w_busy & (mem_ack | w_tmo);
  assign w_prg_cmp  = w_fin & (r_state == PRG);
  assign w_chr_cmp  = w_fin & (r_state == CHR);
  assign w_cmp_data = mem_ack ? mem_rdata
                              : DATA_W'(RDATA_ABORT);

`ifdef CART_ARB_CHR_PRIO_EN
  // PPU fetches have a hard deadline, so CHR wins every tie
  assign w_pick_chr = w_chr_pend;
  assign w_pick_prg = w_prg_pend & ~w_chr_pend;
`else
  assign w_pick_prg = w_prg_pend
                    & (~w_chr_pend | (r_last == SIDE_CHR));
  assign w_pick_chr = w_chr_pend & ~w_pick_prg;
`endif

  cart_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prg (
    .clk        (clk),
    .reset      (reset),
    .i_req      (prg_req),
    .i_addr     (prg_addr),
    .i_we       (prg_we),
    .i_wdata    (prg_wdata),
    .i_cmp      (w_prg_cmp),
    .i_cmp_data (w_cmp_data),
    .o_pend     (w_prg_pend),
    .o_addr     (w_prg_addr),
    .o_we       (w_prg_we),
    .o_wdata    (w_prg_wdata),
    .o_rdata    (prg_rdata),
    .o_done     (prg_done),
    .o_ovr      (w_prg_ovr)
  );

  cart_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chr (
    .clk        (clk),
    .reset      (reset),
    .i_req      (chr_req),
    .i_addr     (chr_addr),
    .i_we       (chr_we),
    .i_wdata    (chr_wdata),
    .i_cmp      (w_chr_cmp),
    .i_cmp_data (w_cmp_data),
    .o_pend     (w_chr_pend),
    .o_addr     (w_chr_addr),
    .o_we       (w_chr_we),
    .o_wdata    (w_chr_wdata),
    .o_rdata    (chr_rdata),
    .o_done     (chr_done),
    .o_ovr      (w_chr_ovr)
  );

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= SIDE_CHR;
      r_wdog      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_prg_ovr | w_chr_ovr | w_tmo) r_err <= 1'b1;
      unique case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (w_pick_prg) begin
            r_state     <= PRG;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= w_prg_addr;
            r_mem_we    <= w_prg_we;
            r_mem_wdata <= w_prg_wdata;
          end else if (w_pick_chr) begin
            r_state     <= CHR;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= w_chr_addr;
            r_mem_we    <= w_chr_we;
            r_mem_wdata <= w_chr_wdata;
          end
        end
        PRG, CHR: begin
          if (w_fin) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_last    <= (r_state == PRG) ? SIDE_PRG
                                          : SIDE_CHR;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
